// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and helpers for the hazard scoreboard: pipeline-register modes,
// stall-count port width, register-file size.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_FLUSH  = 2'd2
    } mode_e;

    localparam int HAZARD_SIGNAL_WIDTH = 3;
    localparam int GPR_ADDR_SPACE      = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_timer.sv
// One per-register countdown: decrements toward zero every cycle, a load takes the larger of
// the new latency and the decremented value so a younger write never shortens the wait.
module scoreboard_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] lat,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] dec;

    always_comb begin
        dec   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        cnt_d = dec;
        if (load && (lat > dec)) begin
            cnt_d = lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-GPR countdown hazard unit driving IF stall and IF_ID / ID_EXE modes; outputs are
// combinational. Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int GPR_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 7,
    parameter int BR_FLUSH = 1,
    localparam int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [ADDR_W-1:0]              id_rs1_addr,
    input  logic                           id_rs1_re,
    input  logic [ADDR_W-1:0]              id_rs2_addr,
    input  logic                           id_rs2_re,
    input  logic [ADDR_W-1:0]              id_rd_addr,
    input  logic                           id_rd_we,
    input  logic [CW-1:0]                  id_lat,
    input  logic                           id_redirect,
    output logic                           if_stall,
    output logic [1:0]                     if_id_mode,
    output logic [1:0]                     id_exe_mode,
    output logic [HAZARD_SIGNAL_WIDTH-1:0] signal_cycle
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0]                    perf_stall_cnt
   ,output logic [31:0]                    perf_flush_cnt
`endif
);

    localparam int unsigned SIG_MAX = (1 << HAZARD_SIGNAL_WIDTH) - 1;

    logic [CW-1:0] cnt_arr  [GPR_NUM];
    logic          busy_arr [GPR_NUM];
    logic [CW-1:0] lat_c;
    logic          busy1;
    logic          busy2;
    logic          hz;
    logic          issue;
    logic          redirect_take;
    logic [2:0]    flush_rem_q;
    logic [2:0]    flush_rem_d;
    int unsigned   wait_max;

    assign cnt_arr[0]  = '0;
    assign busy_arr[0] = 1'b0;
    assign lat_c = (id_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : id_lat;

    for (genvar r = 1; r < GPR_NUM; r++) begin : g_timer
        scoreboard_timer #(.CW(CW)) u_timer (
            .clk  (clk),
            .rst  (rst),
            .load (issue && id_rd_we && (id_rd_addr == ADDR_W'(r))),
            .lat  (lat_c),
            .cnt  (cnt_arr[r]),
            .busy (busy_arr[r])
        );
    end

    always_comb begin
        busy1 = id_valid && id_rs1_re && (id_rs1_addr != '0) && busy_arr[id_rs1_addr];
        busy2 = id_valid && id_rs2_re && (id_rs2_addr != '0) && busy_arr[id_rs2_addr];
        hz    = busy1 || busy2;
        issue = id_valid && !hz;
        // A branch whose operands are still pending cannot have resolved, so redirect waits for issue.
        redirect_take = id_redirect && issue;

        wait_max = max_u(busy1 ? int'(cnt_arr[id_rs1_addr]) : 0,
                         busy2 ? int'(cnt_arr[id_rs2_addr]) : 0);

        if_stall     = hz;
        id_exe_mode  = hz ? MODE_FLUSH : MODE_NORMAL;
        signal_cycle = (wait_max > SIG_MAX) ? HAZARD_SIGNAL_WIDTH'(SIG_MAX)
                                            : HAZARD_SIGNAL_WIDTH'(wait_max);
        if (hz) begin
            if_id_mode = MODE_STALL;
        end else if (redirect_take || (flush_rem_q != '0)) begin
            if_id_mode = MODE_FLUSH;
        end else begin
            if_id_mode = MODE_NORMAL;
        end

        if (redirect_take) begin
            flush_rem_d = 3'(BR_FLUSH - 1);
        end else if (flush_rem_q != '0) begin
            flush_rem_d = flush_rem_q - 3'd1;
        end else begin
            flush_rem_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_rem_q <= '0;
        end else begin
            flush_rem_q <= flush_rem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q;
    logic [31:0] perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q + (hz ? 32'd1 : 32'd0);
        perf_flush_cnt_d = perf_flush_cnt_q + ((if_id_mode == MODE_FLUSH) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios for hazard_scoreboard (BR_FLUSH=2); per-cycle expected outputs go
// through a queue and are compared at the falling edge.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] F = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic       id_rs1_re;
    logic [4:0] id_rs2_addr;
    logic       id_rs2_re;
    logic [4:0] id_rd_addr;
    logic       id_rd_we;
    logic [2:0] id_lat;
    logic       id_redirect;
    logic       if_stall;
    logic [1:0] if_id_mode;
    logic [1:0] id_exe_mode;
    logic [2:0] signal_cycle;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.GPR_NUM(32), .ADDR_W(5), .MAX_LAT(7), .BR_FLUSH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_re    (id_rs2_re),
        .id_rd_addr   (id_rd_addr),
        .id_rd_we     (id_rd_we),
        .id_lat       (id_lat),
        .id_redirect  (id_redirect),
        .if_stall     (if_stall),
        .if_id_mode   (if_id_mode),
        .id_exe_mode  (id_exe_mode),
        .signal_cycle (signal_cycle)
`ifdef HAZARD_PERF_CNT_EN
       ,.perf_stall_cnt (perf_stall_cnt)
       ,.perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One ID cycle: drive the instruction, queue the expected outputs, compare at negedge.
    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] rs1, input logic re1,
                       input logic [4:0] rs2, input logic re2,
                       input logic [4:0] rd, input logic we, input logic [2:0] lat,
                       input logic redir,
                       input logic st, input logic [1:0] ifid, input logic [1:0] idexe,
                       input logic [2:0] sig);
        exp_t e;
        id_valid    = v;
        id_rs1_addr = rs1;
        id_rs1_re   = re1;
        id_rs2_addr = rs2;
        id_rs2_re   = re2;
        id_rd_addr  = rd;
        id_rd_we    = we;
        id_lat      = lat;
        id_redirect = redir;
        e.tag = tag;
        e.exp = {st, ifid, idexe, sig};
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(e.tag, {24'd0, if_stall, if_id_mode, id_exe_mode, signal_cycle}, {24'd0, e.exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [1:0] ifid);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ifid, N, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1_addr = 0; id_rs1_re = 0; id_rs2_addr = 0; id_rs2_re = 0;
        id_rd_addr = 0; id_rd_we = 0; id_lat = 0; id_redirect = 0;
        @(posedge clk); @(posedge clk); #1;
        idle("reset", N);
        rst = 1'b0;

        // Load then use
        cyc("lw_x5",     1, 0, 0, 0, 0, 5, 1, 1, 0, 0, N, N, 0);
        cyc("use_stall", 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, S, F, 1);
        cyc("use_issue", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, N, N, 0);

        // Four-cycle divide, reader on rs2
        cyc("div_x7", 1, 0, 0, 0, 0, 7, 1, 4, 0, 0, N, N, 0);
        for (int i = 4; i >= 1; i--) begin
            cyc($sformatf("div_wait%0d", i), 1, 1, 1, 7, 1, 8, 1, 0, 0, 1, S, F, 3'(i));
        end
        cyc("div_issue", 1, 1, 1, 7, 1, 8, 1, 0, 0, 0, N, N, 0);

        // WAW: a later short write must not shorten the pending long one
        cyc("waw_long",  1, 0, 0, 0, 0, 3, 1, 4, 0, 0, N, N, 0);
        cyc("waw_short", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, N, N, 0);
        for (int i = 3; i >= 1; i--) begin
            cyc($sformatf("waw_wait%0d", i), 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, S, F, 3'(i));
        end
        cyc("waw_issue", 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, N, N, 0);

        // x0 is never tracked; unread busy sources do not stall
        cyc("x0_write",  1, 0, 0, 0, 0, 0, 1, 4, 0, 0, N, N, 0);
        cyc("x0_read",   1, 0, 1, 0, 1, 0, 0, 0, 0, 0, N, N, 0);
        cyc("x10_write", 1, 0, 0, 0, 0, 10, 1, 2, 0, 0, N, N, 0);
        cyc("x10_nore",  1, 10, 0, 10, 0, 0, 0, 0, 0, 0, N, N, 0);
        idle("x10_drain", N);

        // Source equal to rd of the same instruction sees the old count
        cyc("self_dep",  1, 11, 1, 0, 0, 11, 1, 3, 0, 0, N, N, 0);
        cyc("self_next", 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, S, F, 3);
        idle("self_d1", N);
        idle("self_d2", N);

        // Hazard-free redirect: two flush cycles, no stall
        cyc("br_take", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, N, 0);
        idle("br_flush2", F);
        idle("br_done", N);

        // Branch on busy x9: stall first, flush starts when it issues
        cyc("x9_write", 1, 0, 0, 0, 0, 9, 1, 3, 0, 0, N, N, 0);
        idle("x9_age", N);
        cyc("brhz_w2",  1, 9, 1, 0, 0, 0, 0, 0, 1, 1, S, F, 2);
        cyc("brhz_w1",  1, 9, 1, 0, 0, 0, 0, 0, 1, 1, S, F, 1);
        cyc("brhz_go",  1, 9, 1, 0, 0, 0, 0, 0, 1, 0, F, N, 0);
        idle("brhz_f2", F);
        idle("brhz_done", N);

        // Reset in the middle of a pending result
        cyc("x5_long", 1, 0, 0, 0, 0, 5, 1, 4, 0, 0, N, N, 0);
        idle("x5_age", N);
        rst = 1'b1;
        cyc("rst_mid", 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, N, N, 0);
        rst = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
        chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
        cyc("x5_after_rst", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, N, N, 0);

`ifdef HAZARD_PERF_CNT_EN
        cyc("perf_ld",   1, 0, 0, 0, 0, 12, 1, 1, 0, 0, N, N, 0);
        cyc("perf_use",  1, 12, 1, 0, 0, 0, 0, 0, 0, 1, S, F, 1);
        cyc("perf_br",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, N, 0);
        idle("perf_f2", F);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd1);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
